int_ctrl: RTL



---
 rtl/int_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/int_ctrl.sv
// Single-level interrupt controller: edge-latched pending flags, enable mask,
// fixed priority (highest index wins), REQ held until RTI, one-cycle gap after.
module int_ctrl #(
  parameter int          N_SRC      = 8,
  parameter logic [15:0] VEC_BASE   = 16'hF000,
  parameter logic [15:0] VEC_STRIDE = 16'h0010
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [N_SRC-1:0] IRQ,
  input  logic             GIE,
  input  logic             IE_WR,
  input  logic [N_SRC-1:0] IE_DATA,
  input  logic             RTI,
  output logic             REQ,
  output logic [15:0]      ADDR_INT,
  output logic             ACTIVE,
  output logic [3:0]       ACT_ID,
  output logic [N_SRC-1:0] IFG,
  output logic [N_SRC-1:0] IE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SERVE,
    S_GAP
  } state_t;

  localparam logic [N_SRC-1:0] L_ONE = N_SRC'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_SRC-1:0] r_irq_q;
  logic [N_SRC-1:0] r_ifg;
  logic [N_SRC-1:0] r_ie;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_elig;
  logic [N_SRC-1:0] w_clr;
  logic             r_req;
  logic             w_req_nxt;
  logic [15:0]      r_addr;
  logic [15:0]      w_addr_nxt;
  logic [15:0]      w_vec;
  logic [3:0]       r_id;
  logic [3:0]       w_id_nxt;
  logic [3:0]       w_sel;
  logic             w_take;

  assign w_rise = IRQ & ~r_irq_q;
  assign w_elig = r_ifg & r_ie & {N_SRC{GIE}};
  assign w_take = (r_state == S_IDLE) && (|w_elig);

  // Last set bit wins, so the highest index has priority
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (w_elig[i]) w_sel = 4'(i);
    end
  end

  assign w_vec = VEC_BASE + 16'(w_sel) * VEC_STRIDE;
  assign w_clr = w_take ? (L_ONE << w_sel) : '0;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_take) w_state_nxt = S_SERVE;
      S_SERVE: if (RTI) w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_req_nxt  = r_req;
    w_addr_nxt = r_addr;
    w_id_nxt   = r_id;
    unique case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_req_nxt  = 1'b1;
          w_addr_nxt = {w_vec[15:1], 1'b0};
          w_id_nxt   = w_sel;
        end
      end
      S_SERVE: if (RTI) w_req_nxt = 1'b0;
      S_GAP:   w_req_nxt = 1'b0;
      default: w_req_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_req  <= 1'b0;
      r_addr <= '0;
      r_id   <= '0;
    end else begin
      r_req  <= w_req_nxt;
      r_addr <= w_addr_nxt;
      r_id   <= w_id_nxt;
    end
  end

  // A new edge beats the dispatch clear on the same flag
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_irq_q <= '0;
      r_ifg   <= '0;
      r_ie    <= '0;
    end else begin
      r_irq_q <= IRQ;
      r_ifg   <= (r_ifg & ~w_clr) | w_rise;
      if (IE_WR) r_ie <= IE_DATA;
    end
  end

  assign REQ      = r_req;
  assign ACTIVE   = r_req;
  assign ADDR_INT = r_addr;
  assign ACT_ID   = r_id;
  assign IFG      = r_ifg;
  assign IE       = r_ie;

endmodule
